// File: rtl/io_dec_pkg.sv
// io_dec_pkg: shared register offsets, status bits, op bits and FSM encoding for the I/O window decoder
package io_dec_pkg;
    localparam logic [2:0] OFF_BASE_LO = 3'd0;
    localparam logic [2:0] OFF_BASE_HI = 3'd1;
    localparam logic [2:0] OFF_MASK_LO = 3'd2;
    localparam logic [2:0] OFF_MASK_HI = 3'd3;
    localparam logic [2:0] OFF_SLOT    = 3'd4;
    localparam logic [2:0] OFF_OP      = 3'd5;
    localparam logic [2:0] OFF_WAIT    = 3'd6;
    localparam logic [7:0] ADDR_STATUS = 8'h80;
    localparam logic [7:0] ADDR_ERR_LO = 8'h81;
    localparam logic [7:0] ADDR_ERR_HI = 8'h82;
    localparam int STAT_TIMEOUT   = 0;
    localparam int STAT_UNCLAIMED = 1;
    localparam int OP_RD = 0;
    localparam int OP_WR = 1;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;
endpackage

// File: rtl/io_win_regs.sv
// io_win_regs: window register file, status/err_addr registers and combinational config readback
module io_win_regs #(
    parameter int ADDR_W  = 8,
    parameter int NUM_WIN = 4,
    parameter int WAIT_W  = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cfg_we,
    input  logic [7:0]                  cfg_addr,
    input  logic [7:0]                  cfg_wdata,
    output logic [7:0]                  cfg_rdata,
    output logic [NUM_WIN*ADDR_W-1:0]   base_flat,
    output logic [NUM_WIN*ADDR_W-1:0]   mask_flat,
    output logic [NUM_WIN*3-1:0]        slot_flat,
    output logic [NUM_WIN*2-1:0]        op_flat,
    output logic [NUM_WIN*WAIT_W-1:0]   wait_flat,
    input  logic [1:0]                  stat_set,
    input  logic [ADDR_W-1:0]           err_in
);
    import io_dec_pkg::*;

    // address bits above ADDR_W are never stored, so hi bytes read back 0 on narrow buses
    localparam logic [15:0] AMSK = 16'((17'd1 << ADDR_W) - 17'd1);

    logic [15:0]       base_r [NUM_WIN];
    logic [15:0]       mask_r [NUM_WIN];
    logic [2:0]        slot_r [NUM_WIN];
    logic [1:0]        op_r   [NUM_WIN];
    logic [WAIT_W-1:0] wait_r [NUM_WIN];
    logic [1:0]        status;
    logic [15:0]       err_r;
    logic              wsel;
    logic [1:0]        clr;

    assign wsel = !cfg_addr[7] && ({1'b0, cfg_addr[6:3]} < 5'(NUM_WIN));
    assign clr  = (cfg_we && cfg_addr == ADDR_STATUS) ? cfg_wdata[1:0] : 2'b00;

    genvar g;
    for (g = 0; g < NUM_WIN; g++) begin : g_flat
        assign base_flat[g*ADDR_W +: ADDR_W] = base_r[g][ADDR_W-1:0];
        assign mask_flat[g*ADDR_W +: ADDR_W] = mask_r[g][ADDR_W-1:0];
        assign slot_flat[g*3 +: 3]           = slot_r[g];
        assign op_flat[g*2 +: 2]             = op_r[g];
        assign wait_flat[g*WAIT_W +: WAIT_W] = wait_r[g];
    end

    // window register writes, byte addressed with stride 8
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_WIN; i++) begin
                base_r[i] <= '0;
                mask_r[i] <= '0;
                slot_r[i] <= '0;
                op_r[i]   <= '0;
                wait_r[i] <= '0;
            end
        end else if (cfg_we && wsel) begin
            for (int i = 0; i < NUM_WIN; i++) begin
                if (cfg_addr[6:3] == 4'(i)) begin
                    case (cfg_addr[2:0])
                        OFF_BASE_LO: base_r[i] <= {base_r[i][15:8], cfg_wdata} & AMSK;
                        OFF_BASE_HI: base_r[i] <= {cfg_wdata, base_r[i][7:0]} & AMSK;
                        OFF_MASK_LO: mask_r[i] <= {mask_r[i][15:8], cfg_wdata} & AMSK;
                        OFF_MASK_HI: mask_r[i] <= {cfg_wdata, mask_r[i][7:0]} & AMSK;
                        OFF_SLOT:    slot_r[i] <= cfg_wdata[2:0];
                        OFF_OP:      op_r[i]   <= cfg_wdata[1:0];
                        OFF_WAIT:    wait_r[i] <= cfg_wdata[WAIT_W-1:0];
                        default: ;
                    endcase
                end
            end
        end
    end

    // sticky status with write-one-to-clear; a hardware set on the same edge beats the clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status <= '0;
            err_r  <= '0;
        end else begin
            status <= (status & ~clr) | stat_set;
            if (|stat_set) err_r <= 16'(err_in);
        end
    end

    // combinational readback; anything unmapped returns 0
    always_comb begin
        cfg_rdata = 8'h00;
        for (int i = 0; i < NUM_WIN; i++) begin
            if (wsel && cfg_addr[6:3] == 4'(i)) begin
                case (cfg_addr[2:0])
                    OFF_BASE_LO: cfg_rdata = base_r[i][7:0];
                    OFF_BASE_HI: cfg_rdata = base_r[i][15:8];
                    OFF_MASK_LO: cfg_rdata = mask_r[i][7:0];
                    OFF_MASK_HI: cfg_rdata = mask_r[i][15:8];
                    OFF_SLOT:    cfg_rdata = {5'b0, slot_r[i]};
                    OFF_OP:      cfg_rdata = {6'b0, op_r[i]};
                    OFF_WAIT:    cfg_rdata = 8'(wait_r[i]);
                    default:     cfg_rdata = 8'h00;
                endcase
            end
        end
        if (cfg_addr == ADDR_STATUS) cfg_rdata = {6'b0, status};
        if (cfg_addr == ADDR_ERR_LO) cfg_rdata = err_r[7:0];
        if (cfg_addr == ADDR_ERR_HI) cfg_rdata = err_r[15:8];
    end
endmodule

// File: rtl/io_window_decoder.sv
// io_window_decoder: priority window decode of CPU I/O cycles onto slot selects with wait/timeout control
module io_window_decoder #(
    parameter int ADDR_W      = 8,
    parameter int NUM_WIN     = 4,
    parameter int NUM_SLOTS   = 5,
    parameter int WAIT_W      = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ADDR_W-1:0]    addr,
    input  logic                 iorq_n,
    input  logic                 r_w_,
    input  logic [NUM_SLOTS-1:0] dev_rdy,
    input  logic                 irq_int_active,
    input  logic [2:0]           irq_int_slot,
    input  logic                 irq_vec_cycle,
    input  logic                 cfg_we,
    input  logic [7:0]           cfg_addr,
    input  logic [7:0]           cfg_wdata,
    output logic [7:0]           cfg_rdata,
    output logic [NUM_SLOTS-1:0] cs_n,
    output logic                 ready_n,
    output logic                 io_r_w_,
    output logic                 data_oe_n,
    output logic                 data_dir,
    output logic                 win_valid,
    output logic [3:0]           win_index,
    output logic [2:0]           sel_slot,
    output logic                 bus_err
);
    import io_dec_pkg::*;

    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYC - 1);

    logic [NUM_WIN*ADDR_W-1:0] base_flat, mask_flat;
    logic [NUM_WIN*3-1:0]      slot_flat;
    logic [NUM_WIN*2-1:0]      op_flat;
    logic [NUM_WIN*WAIT_W-1:0] wait_flat;
    logic [NUM_WIN-1:0]        hit;
    logic                      m_valid;
    logic [3:0]                m_idx;
    logic [2:0]                m_slot;
    logic [WAIT_W-1:0]         m_wait;
    logic                      vec;
    state_t                    state, state_nx;
    logic                      lat_act, lat_valid, lat_rw;
    logic [3:0]                lat_idx;
    logic [2:0]                lat_slot;
    logic [WAIT_W-1:0]         cnt;
    logic [TW-1:0]             tcnt;
    logic [ADDR_W-1:0]         lat_addr;
    logic [NUM_SLOTS-1:0]      sel;
    logic                      rdy, ev_to, ev_un;
    logic [1:0]                stat_set;

    io_win_regs #(.ADDR_W(ADDR_W), .NUM_WIN(NUM_WIN), .WAIT_W(WAIT_W)) u_regs (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .cfg_rdata(cfg_rdata), .base_flat(base_flat), .mask_flat(mask_flat), .slot_flat(slot_flat),
        .op_flat(op_flat), .wait_flat(wait_flat), .stat_set(stat_set), .err_in(lat_addr)
    );

    assign vec  = irq_vec_cycle & irq_int_active;
    assign sel  = {{(NUM_SLOTS-1){1'b0}}, 1'b1} << lat_slot;
    assign rdy  = |(dev_rdy & sel);
    assign stat_set[STAT_TIMEOUT]   = ev_to;
    assign stat_set[STAT_UNCLAIMED] = ev_un;

    // per-window match: masked address compare, direction enabled, slot in range
    always_comb begin
        hit = '0;
        for (int i = 0; i < NUM_WIN; i++)
            hit[i] = (((addr ^ base_flat[i*ADDR_W +: ADDR_W]) & mask_flat[i*ADDR_W +: ADDR_W]) == '0)
                  && (r_w_ ? op_flat[i*2+OP_RD] : op_flat[i*2+OP_WR])
                  && ({1'b0, slot_flat[i*3 +: 3]} < 4'(NUM_SLOTS));
    end

    // lowest-index hit wins
    always_comb begin
        m_valid = 1'b0;
        m_idx   = '0;
        m_slot  = '0;
        m_wait  = '0;
        for (int i = NUM_WIN - 1; i >= 0; i--) begin
            if (hit[i]) begin
                m_valid = 1'b1;
                m_idx   = 4'(i);
                m_slot  = slot_flat[i*3 +: 3];
                m_wait  = wait_flat[i*WAIT_W +: WAIT_W];
            end
        end
    end

    // cycle sequencing: abort beats everything, unclaimed ends at once, then ready, then timeout
    always_comb begin
        state_nx = state;
        ev_to    = 1'b0;
        ev_un    = 1'b0;
        case (state)
            ST_IDLE: if (!iorq_n) state_nx = ST_WAIT;
            ST_WAIT: begin
                if (iorq_n) state_nx = ST_IDLE;
                else if (!lat_act) begin
                    state_nx = ST_DONE;
                    ev_un    = 1'b1;
                end else if (cnt == '0 && rdy) state_nx = ST_DONE;
                else if (tcnt == TMAX) begin
                    state_nx = ST_DONE;
                    ev_to    = 1'b1;
                end
            end
            ST_DONE: if (iorq_n) state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // state register, cycle latch at entry, wait/timeout counters; latches clear on return to idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            lat_act   <= 1'b0;
            lat_valid <= 1'b0;
            lat_rw    <= 1'b1;
            lat_idx   <= '0;
            lat_slot  <= '0;
            cnt       <= '0;
            tcnt      <= '0;
            lat_addr  <= '0;
            bus_err   <= 1'b0;
        end else begin
            state   <= state_nx;
            bus_err <= ev_to;
            if (state == ST_IDLE && !iorq_n) begin
                lat_act   <= vec | m_valid;
                lat_valid <= !vec && m_valid;
                lat_idx   <= vec ? 4'd0 : m_idx;
                lat_slot  <= vec ? irq_int_slot : m_slot;
                lat_rw    <= r_w_;
                cnt       <= vec ? '0 : m_wait;
                tcnt      <= '0;
                lat_addr  <= addr;
            end else if (state_nx == ST_IDLE) begin
                lat_act   <= 1'b0;
                lat_valid <= 1'b0;
                lat_rw    <= 1'b1;
                lat_idx   <= '0;
                lat_slot  <= '0;
                cnt       <= '0;
                tcnt      <= '0;
            end else if (state == ST_WAIT) begin
                if (cnt != '0) cnt <= cnt - 1'b1;
                tcnt <= tcnt + 1'b1;
            end
        end
    end

    assign cs_n      = lat_act ? ~sel : '1;
    assign data_oe_n = !lat_act;
    assign ready_n   = state != ST_WAIT;
    assign io_r_w_   = lat_rw;
    assign data_dir  = (state != ST_IDLE) & lat_rw;
    assign win_valid = lat_valid;
    assign win_index = lat_idx;
    assign sel_slot  = lat_slot;
endmodule
